// File: rtl/note_sequencer_pkg.sv
// note_sequencer shared definitions: FSM state encoding, rest marker
// and event entry layout {note[3:0], octave[1:0], dur[DUR_W-1:0]}.
package note_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REC   = 2'd1,
        ST_FETCH = 2'd2,
        ST_PLAY  = 2'd3
    } seq_state_e;

    localparam logic [3:0] REST_NOTE = 4'hF;
    localparam logic [1:0] REST_OCT  = 2'd0;

    localparam int NOTE_W    = 4;
    localparam int OCT_W     = 2;
    // Header bits ahead of the duration field in every entry.
    localparam int ENT_HDR_W = NOTE_W + OCT_W;

endpackage

// File: rtl/note_event_ram.sv
// note_event_ram: single-port synchronous RAM, registered read.
// Ports: clk, we_i, addr_i, wdata_i -> rdata_o (one cycle later).
module note_event_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on storage or read register so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: records key events with tick timing, replays them.
// In: rec_en, play_start/stop, note_press/release, note_in, octave_in.
// Out: out_note/out_octave/out_gate, busy, full, count, state.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int DUR_W    = 8,
    parameter int TICK_DIV = 500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rec_en,
    input  logic              play_start,
    input  logic              play_stop,
    input  logic              note_press,
    input  logic              note_release,
    input  logic [3:0]        note_in,
    input  logic [1:0]        octave_in,
    output logic [3:0]        out_note,
    output logic [1:0]        out_octave,
    output logic              out_gate,
    output logic              busy,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic [1:0]        state
);

    localparam int ENT_W = ENT_HDR_W + DUR_W;
    localparam int PS_W  = $clog2(TICK_DIV + 1);

    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [PS_W-1:0]   PS_ONE   = PS_W'(1);
    localparam logic [DUR_W-1:0]  DUR_MAX  = '1;
    localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADR_ONE  = ADDR_W'(1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, ram_addr;
    logic [PS_W-1:0]   presc_q, presc_d;
    logic              open_q, open_d;
    logic [3:0]        note_q, note_d;
    logic [1:0]        oct_q, oct_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [DUR_W-1:0]  gap_q, gap_d;
    logic [DUR_W-1:0]  rem_q, rem_d;
    logic [3:0]        onote_q, onote_d;
    logic [1:0]        ooct_q, ooct_d;
    logic              gate_q, gate_d;

    logic              tick, is_last, expire, full_w;
    logic              we, ram_we;
    logic [ENT_W-1:0]  wdata, rdata, close_ent;
    logic [3:0]        rd_note;
    logic [1:0]        rd_oct;
    logic [DUR_W-1:0]  rd_dur;

    assign tick      = (presc_q == PS_LAST);
    assign full_w    = (count_q == CNT_FULL);
    assign is_last   = ({1'b0, rd_addr_q} == count_q - CNT_ONE);
    assign expire    = tick && (rem_q <= DUR_ONE);
    assign {rd_note, rd_oct, rd_dur} = rdata;
    // A note always lasts at least one tick once stored.
    assign close_ent = {note_q, oct_q, (dur_q == '0) ? DUR_ONE : dur_q};
    assign ram_we    = we && !full_w;
    // Reads use the next address so data is ready during FETCH.
    assign ram_addr  = (state_q == ST_REC) ? count_q[ADDR_W-1:0]
                                           : rd_addr_d;

    note_event_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (ENT_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wdata),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            rd_addr_q <= '0;
            presc_q   <= '0;
            open_q    <= 1'b0;
            note_q    <= '0;
            oct_q     <= '0;
            dur_q     <= '0;
            gap_q     <= '0;
            rem_q     <= '0;
            onote_q   <= '0;
            ooct_q    <= '0;
            gate_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_addr_q <= rd_addr_d;
            presc_q   <= presc_d;
            open_q    <= open_d;
            note_q    <= note_d;
            oct_q     <= oct_d;
            dur_q     <= dur_d;
            gap_q     <= gap_d;
            rem_q     <= rem_d;
            onote_q   <= onote_d;
            ooct_q    <= ooct_d;
            gate_q    <= gate_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rec_en) begin
                    state_d = ST_REC;
                end else if (play_start && count_q != '0) begin
                    state_d = ST_FETCH;
                end
            end
            ST_REC: begin
                if (!rec_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = play_stop ? ST_IDLE : ST_PLAY;
            end
            ST_PLAY: begin
                if (play_stop) begin
                    state_d = ST_IDLE;
                end else if (expire) begin
                    state_d = is_last ? ST_IDLE : ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d   = count_q;
        rd_addr_d = rd_addr_q;
        presc_d   = tick ? '0 : presc_q + PS_ONE;
        open_d    = open_q;
        note_d    = note_q;
        oct_d     = oct_q;
        dur_d     = dur_q;
        gap_d     = gap_q;
        rem_d     = rem_q;
        onote_d   = onote_q;
        ooct_d    = ooct_q;
        gate_d    = gate_q;
        we        = 1'b0;
        wdata     = close_ent;

        if (tick && open_q && dur_q != DUR_MAX) begin
            dur_d = dur_q + DUR_ONE;
        end
        if (tick && !open_q && gap_q != DUR_MAX) begin
            gap_d = gap_q + DUR_ONE;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (rec_en) begin
                    count_d = '0;
                    open_d  = 1'b0;
                    gap_d   = '0;
                end else if (play_start && count_q != '0) begin
                    rd_addr_d = '0;
                end
            end
            ST_REC: begin
                if (!rec_en) begin
                    we     = open_q;
                    open_d = 1'b0;
                end else if (note_press) begin
                    // Silence before this press is stored as a rest,
                    // but only after a previous note closed.
                    if (open_q) begin
                        we = 1'b1;
                    end else if (count_q != '0 && gap_q != '0) begin
                        we    = 1'b1;
                        wdata = {REST_NOTE, REST_OCT, gap_q};
                    end
                    open_d  = 1'b1;
                    note_d  = note_in;
                    oct_d   = octave_in;
                    dur_d   = '0;
                    presc_d = '0;
                end else if (note_release && open_q) begin
                    we     = 1'b1;
                    open_d = 1'b0;
                    gap_d  = '0;
                end
            end
            ST_FETCH: begin
                if (play_stop) begin
                    gate_d = 1'b0;
                end else begin
                    onote_d = rd_note;
                    ooct_d  = rd_oct;
                    gate_d  = (rd_note != REST_NOTE);
                    rem_d   = rd_dur;
                    presc_d = '0;
                end
            end
            ST_PLAY: begin
                if (play_stop) begin
                    gate_d = 1'b0;
                end else if (expire) begin
                    // Gate drops through FETCH so repeats retrigger.
                    gate_d = 1'b0;
                    if (!is_last) begin
                        rd_addr_d = rd_addr_q + ADR_ONE;
                    end
                end else if (tick) begin
                    rem_d = rem_q - DUR_ONE;
                end
            end
            default: gate_d = 1'b0;
        endcase

        if (ram_we) begin
            count_d = count_q + CNT_ONE;
        end
    end

    assign out_note   = onote_q;
    assign out_octave = ooct_q;
    assign out_gate   = gate_q;
    assign busy       = (state_q != ST_IDLE);
    assign full       = full_w;
    assign count      = count_q;
    assign state      = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed scenarios for note_sequencer with
// DEPTH=4, TICK_DIV=4; each task checks its own expected values.
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rec_en = 1'b0;
    logic       play_start = 1'b0;
    logic       play_stop = 1'b0;
    logic       note_press = 1'b0;
    logic       note_release = 1'b0;
    logic [3:0] note_in = '0;
    logic [1:0] octave_in = '0;
    logic [3:0] out_note;
    logic [1:0] out_octave;
    logic       out_gate;
    logic       busy;
    logic       full;
    logic [2:0] count;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;

    int         hi_len[$];
    int         lo_len[$];
    logic [3:0] hi_note[$];
    logic [1:0] hi_oct[$];
    bit         cap_to;

    note_sequencer #(
        .DEPTH    (4),
        .ADDR_W   (2),
        .DUR_W    (8),
        .TICK_DIV (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rec_en       (rec_en),
        .play_start   (play_start),
        .play_stop    (play_stop),
        .note_press   (note_press),
        .note_release (note_release),
        .note_in      (note_in),
        .octave_in    (octave_in),
        .out_note     (out_note),
        .out_octave   (out_octave),
        .out_gate     (out_gate),
        .busy         (busy),
        .full         (full),
        .count        (count),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] n, input logic [1:0] o);
        note_in = n;
        octave_in = o;
        note_press = 1'b1;
        cyc(1);
        note_press = 1'b0;
    endtask

    task automatic release_key();
        note_release = 1'b1;
        cyc(1);
        note_release = 1'b0;
    endtask

    // Holding 4*k cycles stores exactly k ticks.
    task automatic record_note(input logic [3:0] n, input logic [1:0] o,
                               input int k);
        press(n, o);
        cyc(4 * k);
        release_key();
    endtask

    task automatic play_capture(input int budget);
        int run;
        int n;
        logic prev;
        hi_len.delete();
        lo_len.delete();
        hi_note.delete();
        hi_oct.delete();
        play_start = 1'b1;
        cyc(1);
        play_start = 1'b0;
        prev = 1'b0;
        run = 0;
        n = 0;
        while (state != 2'd0 && n < budget) begin
            if (out_gate !== prev) begin
                if (out_gate) begin
                    if (hi_len.size() != 0) lo_len.push_back(run);
                    hi_note.push_back(out_note);
                    hi_oct.push_back(out_octave);
                end else begin
                    hi_len.push_back(run);
                end
                run = 0;
                prev = out_gate;
            end
            run++;
            n++;
            cyc(1);
        end
        if (prev) hi_len.push_back(run);
        cap_to = (n >= budget);
    endtask

    task automatic test_reset();
        cyc(3);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL rst_full got=%0d exp=0", full); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0d exp=0", busy); end
        checks++; if (out_gate !== 1'b0) begin failures++; $display("FAIL rst_gate got=%0d exp=0", out_gate); end
        checks++; if (out_note !== 4'd0) begin failures++; $display("FAIL rst_note got=%0d exp=0", out_note); end
        checks++; if (out_octave !== 2'd0) begin failures++; $display("FAIL rst_oct got=%0d exp=0", out_octave); end
        reset = 1'b1;
        cyc(2);
    endtask

    task automatic test_play_empty();
        play_start = 1'b1;
        cyc(1);
        play_start = 1'b0;
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL empty_play_state got=%0d exp=0", state); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL empty_play_busy got=%0d exp=0", busy); end
    endtask

    task automatic test_single_note();
        rec_en = 1'b1;
        cyc(1);
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL single_rec_state got=%0d exp=1", state); end
        record_note(4'd3, 2'd1, 5);
        rec_en = 1'b0;
        cyc(1);
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
        play_capture(500);
        checks++; if (cap_to) begin failures++; $display("FAIL single_timeout got=1 exp=0"); end
        checks++; if (hi_len.size() !== 1) begin failures++; $display("FAIL single_runs got=%0d exp=1", hi_len.size()); end
        checks++; if (hi_len[0] !== 20) begin failures++; $display("FAIL single_gate_len got=%0d exp=20", hi_len[0]); end
        checks++; if (hi_note[0] !== 4'd3) begin failures++; $display("FAIL single_note got=%0d exp=3", hi_note[0]); end
        checks++; if (hi_oct[0] !== 2'd1) begin failures++; $display("FAIL single_oct got=%0d exp=1", hi_oct[0]); end
        checks++; if (out_gate !== 1'b0) begin failures++; $display("FAIL single_end_gate got=%0d exp=0", out_gate); end
    endtask

    task automatic test_rest_gap();
        rec_en = 1'b1;
        cyc(1);
        record_note(4'd5, 2'd2, 2);
        cyc(12);
        record_note(4'd9, 2'd0, 2);
        rec_en = 1'b0;
        cyc(1);
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL gap_count got=%0d exp=3", count); end
        play_capture(500);
        checks++; if (cap_to) begin failures++; $display("FAIL gap_timeout got=1 exp=0"); end
        checks++; if (hi_len.size() !== 2) begin failures++; $display("FAIL gap_runs got=%0d exp=2", hi_len.size()); end
        checks++; if (hi_len[0] !== 8) begin failures++; $display("FAIL gap_a_len got=%0d exp=8", hi_len[0]); end
        checks++; if (lo_len[0] !== 14) begin failures++; $display("FAIL gap_low_len got=%0d exp=14", lo_len[0]); end
        checks++; if (hi_len[1] !== 8) begin failures++; $display("FAIL gap_b_len got=%0d exp=8", hi_len[1]); end
        checks++; if (hi_note[0] !== 4'd5) begin failures++; $display("FAIL gap_a_note got=%0d exp=5", hi_note[0]); end
        checks++; if (hi_oct[0] !== 2'd2) begin failures++; $display("FAIL gap_a_oct got=%0d exp=2", hi_oct[0]); end
        checks++; if (hi_note[1] !== 4'd9) begin failures++; $display("FAIL gap_b_note got=%0d exp=9", hi_note[1]); end
    endtask

    task automatic test_dur_limits();
        rec_en = 1'b1;
        cyc(1);
        record_note(4'd2, 2'd3, 0);
        record_note(4'd7, 2'd2, 300);
        rec_en = 1'b0;
        cyc(1);
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL lim_count got=%0d exp=2", count); end
        play_capture(2000);
        checks++; if (cap_to) begin failures++; $display("FAIL lim_timeout got=1 exp=0"); end
        checks++; if (hi_len[0] !== 4) begin failures++; $display("FAIL lim_min_len got=%0d exp=4", hi_len[0]); end
        checks++; if (hi_len[1] !== 1020) begin failures++; $display("FAIL lim_sat_len got=%0d exp=1020", hi_len[1]); end
        checks++; if (lo_len[0] !== 1) begin failures++; $display("FAIL lim_retrig got=%0d exp=1", lo_len[0]); end
    endtask

    task automatic test_full();
        rec_en = 1'b1;
        cyc(1);
        for (int i = 0; i < 6; i++) begin
            record_note(4'(i + 1), 2'(i), 0);
        end
        rec_en = 1'b0;
        cyc(1);
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d exp=4", count); end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_flag got=%0d exp=1", full); end
        play_capture(500);
        checks++; if (cap_to) begin failures++; $display("FAIL full_timeout got=1 exp=0"); end
        checks++; if (hi_len.size() !== 4) begin failures++; $display("FAIL full_runs got=%0d exp=4", hi_len.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (hi_note[i] !== 4'(i + 1)) begin failures++; $display("FAIL full_note%0d got=%0d exp=%0d", i, hi_note[i], i + 1); end
            checks++; if (hi_len[i] !== 4) begin failures++; $display("FAIL full_len%0d got=%0d exp=4", i, hi_len[i]); end
        end
        checks++; if (lo_len[2] !== 1) begin failures++; $display("FAIL full_retrig got=%0d exp=1", lo_len[2]); end
    endtask

    task automatic test_stop();
        play_start = 1'b1;
        cyc(1);
        play_start = 1'b0;
        cyc(2);
        checks++; if (out_gate !== 1'b1) begin failures++; $display("FAIL stop_pre_gate got=%0d exp=1", out_gate); end
        play_stop = 1'b1;
        cyc(1);
        play_stop = 1'b0;
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL stop_state got=%0d exp=0", state); end
        checks++; if (out_gate !== 1'b0) begin failures++; $display("FAIL stop_gate got=%0d exp=0", out_gate); end
        // Stop lands on the same edge as the first entry's expiry.
        play_start = 1'b1;
        cyc(1);
        play_start = 1'b0;
        cyc(4);
        play_stop = 1'b1;
        cyc(1);
        play_stop = 1'b0;
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL stop_exp_state got=%0d exp=0", state); end
        checks++; if (out_gate !== 1'b0) begin failures++; $display("FAIL stop_exp_gate got=%0d exp=0", out_gate); end
    endtask

    task automatic test_rec_priority();
        rec_en = 1'b1;
        play_start = 1'b1;
        cyc(1);
        play_start = 1'b0;
        checks++; if (state !== 2'd1) begin failures++; $display("FAIL prio_state got=%0d exp=1", state); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL prio_count got=%0d exp=0", count); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL prio_full got=%0d exp=0", full); end
        rec_en = 1'b0;
        cyc(1);
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL prio_idle got=%0d exp=0", state); end
    endtask

    task automatic test_reset_mid_play();
        rec_en = 1'b1;
        cyc(1);
        record_note(4'd4, 2'd2, 3);
        rec_en = 1'b0;
        cyc(1);
        play_start = 1'b1;
        cyc(1);
        play_start = 1'b0;
        cyc(5);
        checks++; if (out_gate !== 1'b1) begin failures++; $display("FAIL rmid_pre_gate got=%0d exp=1", out_gate); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (state !== 2'd0) begin failures++; $display("FAIL rmid_state got=%0d exp=0", state); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", count); end
        checks++; if (out_gate !== 1'b0) begin failures++; $display("FAIL rmid_gate got=%0d exp=0", out_gate); end
        checks++; if (out_note !== 4'd0) begin failures++; $display("FAIL rmid_note got=%0d exp=0", out_note); end
        checks++; if (out_octave !== 2'd0) begin failures++; $display("FAIL rmid_oct got=%0d exp=0", out_octave); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%0d exp=0", busy); end
        cyc(1);
        reset = 1'b1;
        cyc(1);
    endtask

    initial begin
        test_reset();
        test_play_empty();
        test_single_note();
        test_rest_gap();
        test_dur_limits();
        test_full();
        test_stop();
        test_rec_priority();
        test_reset_mid_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Records live note events from the keyboard decode path into a small event memory, then replays them at recorded timing. Each event holds note, octave and duration in ticks. During playback the block drives note/octave and a gate toward the note datapath/audio path, replacing live keyboard input. It sits between convert_keyboard_input and the control/datapath pair.

Parameters:
DEPTH, 16, number of event entries (power of two)
ADDR_W, 4, log2(DEPTH)
DUR_W, 8, duration field width in ticks
TICK_DIV, 500000, clk cycles per tick (10 ms at 50 MHz)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-low reset
rec_en  in  1  level; high = record mode requested
play_start  in  1  1-cycle strobe; start playback from entry 0
play_stop  in  1  1-cycle strobe; abort playback
note_press  in  1  1-cycle strobe; key make with valid note
note_release  in  1  1-cycle strobe; key break
note_in  in  4  note code
octave_in  in  2  octave code
out_note  out  4  playback note (4'hF = rest)
out_octave  out  2  playback octave
out_gate  out  1  high while a non-rest entry sounds
busy  out  1  high in REC, FETCH or PLAY
full  out  1  entry count == DEPTH
count  out  ADDR_W+1  entries stored
state  out  2  IDLE=0, REC=1, FETCH=2, PLAY=3

Behaviour:
- Reset (async, active-low): state IDLE, count 0, full 0, out_note 0, out_octave 0, out_gate 0, busy 0, prescaler 0, open-entry flag 0.
- Tick: prescaler counts 0..TICK_DIV-1; tick strobe on wrap. Prescaler clears whenever an entry opens or playback loads an entry.
- IDLE: rec_en high -> REC, clear count and full (new take overwrites). play_start with count>0 -> FETCH with rd_addr 0. play_start with count==0 is ignored. rec_en has priority over play_start in the same cycle.
- REC: note_press opens an entry: latch note/octave, clear duration counter. If a gap of >=1 tick has elapsed since the previous close, first write a rest entry (note 4'hF, octave 0, duration = gap ticks). Duration and gap counters increment on tick and saturate at 2^DUR_W-1. note_release, or a new note_press while an entry is open, closes it: write {note, octave, max(duration,1)}; a press then also opens the next entry in the same cycle. rec_en falling closes any open entry, then goes to IDLE. Writes at count==DEPTH are dropped and full stays 1. play_start/play_stop are ignored in REC.
- FETCH: one cycle for the registered memory read -> PLAY. Load out_note/out_octave and the remaining duration. out_gate = (note != 4'hF).
- PLAY: remaining duration decrements on tick. At 0: if rd_addr==count-1 -> IDLE with out_gate 0, else increment rd_addr -> FETCH. out_gate is forced 0 during FETCH so consecutive equal notes retrigger.
- play_stop in FETCH/PLAY -> IDLE next cycle, out_gate 0. play_stop has priority over tick expiry in the same cycle.
- Reset mid-operation aborts everything. The memory contents are not cleared, but count returns 0, so they are unreachable.
- Live passthrough is not this block's job. Top-level muxing uses busy.

Decomposition:
- Shared package/header: state encodings, REST_NOTE = 4'hF, and the entry field layout {note[3:0], octave[1:0], dur[DUR_W-1:0]}.
- One sub-module: note_event_ram. Single-port synchronous RAM, DEPTH x (6+DUR_W), 1-cycle registered read, write-enable. Inferable as M10K.

Test Plan:
(All with TICK_DIV=4, DEPTH=4.)
- Reset mid-PLAY -> all outputs 0, state 0, count 0 on the next edge without a clock.
- REC: press note 3/oct 1, release after 5 ticks, rec_en low -> count=1. Play -> out_note=3, out_octave=1, gate high 20 cycles (+/-4), then IDLE.
- REC: press A, release at 2 ticks, wait 3 ticks, press B, release at 2 ticks -> count=3 (A, rest dur 3, B). Playback gate pattern: 2 ticks high, 3 low, 2 high. Gate drops 1 cycle between entries.
- Press/release within 1 tick -> stored duration 1. Hold 300 ticks with DUR_W=8 -> stored 255.
- Record 6 short notes into DEPTH=4 -> count=4, full=1, extra writes dropped. Playback plays exactly 4 entries.
- play_stop during PLAY and simultaneous with expiry -> IDLE next cycle, gate 0. play_start with count=0 -> stays IDLE. rec_en and play_start together -> REC.
